bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, multi-slave arbiter for the serial system bus; it sits directly upstream of each master port. It takes bus requests from both masters, grants one, and shifts in the serial slave-select bits the granted master sends. It then drives the master/slave mux selects and holds the bus until the master signals transaction done. It is the counterpart of the master port's approval_request / approval_grant / tx_slave_select / trans_done / bus_busy / arbitor_busy pins.

## Interface
- SLAVE_LEN, 2, width of the serial slave index
- NUM_SLAVES, 3, number of populated slaves; valid indices are 0..NUM_SLAVES-1 (NUM_SLAVES ≤ 2^SLAVE_LEN)

Ports:
- clk  in  1  bus clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-low
- m1_request, m2_request  in  1  approval_request from master 1 / master 2
- m1_slave_select, m2_slave_select  in  1  serial slave index (tx_slave_select), MSB first
- m1_trans_done, m2_trans_done  in  1  trans_done from each master
- m1_grant, m2_grant  out  1  approval_grant to each master
- arbitor_busy  out  1  high whenever the FSM is not IDLE
- bus_busy  out  1  high in CONNECT only
- master_sel  out  1  bus mux select: 0 = M1, 1 = M2
- slave_sel  out  SLAVE_LEN  registered slave index for the bus mux
- slave_en  out  NUM_SLAVES  one-hot slave enable, valid in CONNECT only
- sel_error  out  1  one-cycle pulse on an out-of-range slave index

## Operation
- FSM states: IDLE, SELECT, CONNECT.
- **IDLE**
  - With any request high, the winner is chosen and the FSM moves to SELECT.
  - The winner's grant and master_sel are registered high and set on that edge.
  - The bit counter clears to 0.
- **Tie-break:** master 1 wins when both requests are high (see Configuration).
- **SELECT**
  - Each cycle, the granted master's slave_select bit is shifted into the index register, MSB first, and the counter increments.
  - After SLAVE_LEN samples, the index is checked:
    - Index < NUM_SLAVES: go to CONNECT. slave_en = one-hot(index); slave_sel = index.
    - Index out of range: go to IDLE. Grant drops and sel_error pulses for one cycle.
- **CONNECT**
  - Grant, master_sel, slave_sel and slave_en are held.
  - When the granted master's trans_done goes high, the next edge returns to IDLE and clears grant, slave_en and bus_busy.
- **Abort:** if the granted master drops its request in SELECT or CONNECT, the FSM returns to IDLE on the next edge and clears the same outputs as a normal release. sel_error is not raised.
- The non-granted master's request, slave_select and trans_done inputs are ignored until the FSM returns to IDLE.
- IDLE always lasts at least one cycle between transactions.

## Timing
- **Reset values:** every output is 0. state = IDLE, counter = 0, index = 0, last-served = M2.
- **Reset mid-transaction:** reset asserted in any state forces all outputs to 0 immediately (asynchronous). The FSM restarts in IDLE.
- **Request to grant:** one cycle. The request is sampled at edge E0 and grant is high after E0.
- **Slave-select sampling:**
  - The master drives bit k (MSB = k 0) during the k-th cycle after grant rises.
  - The arbiter samples it at edge E(k+1).
  - slave_en and bus_busy rise after edge E(SLAVE_LEN+1), i.e. SLAVE_LEN+1 cycles after the request is sampled.
- **Release:** trans_done high at edge En drops grant, bus_busy and slave_en after En. The earliest re-grant is after En+1.
- **Request during release:** a request from the other master held through the release cycle is granted on the edge after the IDLE cycle.
- **trans_done in SELECT:** ignored.

## Configuration
- **ARB_ROUND_ROBIN_EN**
  - Defined: a last-served register records the master of every grant.
  - On a simultaneous request, the master not served last wins.
  - After reset, last-served = M2, so M1 wins the first tie.
- **Undefined:** fixed priority. M1 always wins ties and the last-served register is not implemented.

## Structure
- **bus_pkg (shared):**
  - arb_state_t enum (IDLE, SELECT, CONNECT)
  - master index constants (MASTER_1 = 0, MASTER_2 = 1)
  - default SLAVE_LEN / NUM_SLAVES constants, shared with the master and slave ports
- **Sub-module slave_decoder:** combinational index → one-hot with range check. It produces slave_en and an in-range flag and is instantiated once. The FSM, counter, shift register and priority logic stay in bus_arbiter.

## Test plan
- **M1 alone:** m1_request=1, serial bits 1,0 → m1_grant=1 after 1 cycle. Then slave_sel=2, slave_en=3'b100, bus_busy=1 after 3 cycles. m1_trans_done pulse → all outputs 0 on the next edge.
- **Simultaneous requests, macro undefined, repeated twice:** M1 granted both times, master_sel=0. Macro defined: M1 first, then M2 (master_sel=1) after M1's release plus one IDLE cycle.
- **Out-of-range index:** M2 sends 1,1 with NUM_SLAVES=3 → sel_error pulses 1 cycle, m2_grant drops, slave_en stays 0, FSM back in IDLE.
- **Abort:** M1 drops m1_request in CONNECT → grant, bus_busy and slave_en go to 0 on the next edge. sel_error stays 0.
- **Reset mid-CONNECT:** reset driven low → all outputs 0 without waiting for a clock edge. After reset goes high, a new M2 request is granted normally in 1 cycle.
- **Non-granted master ignored:** M2 toggles m2_trans_done and m2_slave_select while M1 is in CONNECT → no change to any output.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: arbiter FSM states, master ids and default bus geometry.
package bus_pkg;

    localparam int unsigned DEFAULT_SLAVE_LEN  = 2;
    localparam int unsigned DEFAULT_NUM_SLAVES = 3;

    localparam logic MASTER_1 = 1'b0;
    localparam logic MASTER_2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CONNECT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter <-> master-port handshake bundle; "slave" is the arbiter side, "master" the requester side.
interface bus_arbiter_if #(
    parameter int unsigned SLAVE_LEN  = bus_pkg::DEFAULT_SLAVE_LEN,
    parameter int unsigned NUM_SLAVES = bus_pkg::DEFAULT_NUM_SLAVES
);
    logic                  m1_request;
    logic                  m2_request;
    logic                  m1_slave_select;
    logic                  m2_slave_select;
    logic                  m1_trans_done;
    logic                  m2_trans_done;
    logic                  m1_grant;
    logic                  m2_grant;
    logic                  arbitor_busy;
    logic                  bus_busy;
    logic                  master_sel;
    logic [SLAVE_LEN-1:0]  slave_sel;
    logic [NUM_SLAVES-1:0] slave_en;
    logic                  sel_error;

    modport slave (
        input  m1_request, m2_request, m1_slave_select, m2_slave_select,
        input  m1_trans_done, m2_trans_done,
        output m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel,
        output slave_sel, slave_en, sel_error
    );

    modport master (
        output m1_request, m2_request, m1_slave_select, m2_slave_select,
        output m1_trans_done, m2_trans_done,
        input  m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel,
        input  slave_sel, slave_en, sel_error
    );
endinterface

// File: rtl/bus_arbiter_slave_decoder.sv
// Combinational slave index decode: one-hot enable plus in-range flag.
module slave_decoder #(
    parameter int unsigned SLAVE_LEN  = bus_pkg::DEFAULT_SLAVE_LEN,
    parameter int unsigned NUM_SLAVES = bus_pkg::DEFAULT_NUM_SLAVES
) (
    input  logic [SLAVE_LEN-1:0]  index,
    output logic [NUM_SLAVES-1:0] slave_en_c,
    output logic                  in_range_c
);
    localparam int unsigned         CMP_W = SLAVE_LEN + 1;
    localparam logic [CMP_W-1:0]    LIMIT = CMP_W'(NUM_SLAVES);

    always_comb begin
        in_range_c = ({1'b0, index} < LIMIT);
        slave_en_c = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            slave_en_c[i] = (index == SLAVE_LEN'(i));
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter: grant, shift in slave index, connect, release.
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed M1 priority.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned SLAVE_LEN  = DEFAULT_SLAVE_LEN,
    parameter int unsigned NUM_SLAVES = DEFAULT_NUM_SLAVES
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(SLAVE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLAVE_LEN);

    arb_state_t            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [SLAVE_LEN-1:0]  index;
    logic                  m1_grant;
    logic                  m2_grant;
    logic                  arbitor_busy;
    logic                  bus_busy;
    logic                  master_sel;
    logic [SLAVE_LEN-1:0]  slave_sel;
    logic [NUM_SLAVES-1:0] slave_en;
    logic                  sel_error;

    logic [NUM_SLAVES-1:0] dec_en_c;
    logic                  in_range_c;
    logic                  any_req_c;
    logic                  winner_c;
    logic                  gnt_req_c;
    logic                  gnt_sel_c;
    logic                  gnt_done_c;
    logic                  bad_index_c;
    logic                  release_c;

    slave_decoder #(
        .SLAVE_LEN  (SLAVE_LEN),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_slave_decoder (
        .index      (index),
        .slave_en_c (dec_en_c),
        .in_range_c (in_range_c)
    );

    assign any_req_c = bus.m1_request | bus.m2_request;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_served;

    // Records the master of every grant; starts as M2 so M1 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_served <= MASTER_2;
        end else if (state == IDLE && any_req_c) begin
            last_served <= winner_c;
        end
    end

    always_comb begin
        winner_c = MASTER_1;
        if (bus.m1_request && bus.m2_request) begin
            winner_c = (last_served == MASTER_1) ? MASTER_2 : MASTER_1;
        end else if (bus.m2_request) begin
            winner_c = MASTER_2;
        end
    end
`else
    always_comb begin
        winner_c = (bus.m2_request && !bus.m1_request) ? MASTER_2 : MASTER_1;
    end
`endif

    // Only the granted master's inputs are observed outside IDLE.
    always_comb begin
        gnt_req_c   = (master_sel == MASTER_2) ? bus.m2_request      : bus.m1_request;
        gnt_sel_c   = (master_sel == MASTER_2) ? bus.m2_slave_select : bus.m1_slave_select;
        gnt_done_c  = (master_sel == MASTER_2) ? bus.m2_trans_done   : bus.m1_trans_done;
        bad_index_c = (state == SELECT) && gnt_req_c && (bit_cnt == CNT_LAST) && !in_range_c;
        release_c   = 1'b0;
        if (state != IDLE) begin
            if (!gnt_req_c) begin
                release_c = 1'b1;
            end else if (state == CONNECT && gnt_done_c) begin
                release_c = 1'b1;
            end else if (bad_index_c) begin
                release_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            index        <= '0;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            arbitor_busy <= 1'b0;
            bus_busy     <= 1'b0;
            master_sel   <= MASTER_1;
            slave_sel    <= '0;
            slave_en     <= '0;
            sel_error    <= 1'b0;
        end else begin
            sel_error <= bad_index_c;
            if (release_c) begin
                state        <= IDLE;
                m1_grant     <= 1'b0;
                m2_grant     <= 1'b0;
                arbitor_busy <= 1'b0;
                bus_busy     <= 1'b0;
                master_sel   <= MASTER_1;
                slave_sel    <= '0;
                slave_en     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_req_c) begin
                            state        <= SELECT;
                            m1_grant     <= (winner_c == MASTER_1);
                            m2_grant     <= (winner_c == MASTER_2);
                            master_sel   <= winner_c;
                            arbitor_busy <= 1'b1;
                            bit_cnt      <= '0;
                            index        <= '0;
                        end
                    end
                    SELECT: begin
                        // After SLAVE_LEN samples the registered index is decoded one cycle later.
                        if (bit_cnt == CNT_LAST) begin
                            state     <= CONNECT;
                            slave_sel <= index;
                            slave_en  <= dec_en_c;
                            bus_busy  <= 1'b1;
                        end else begin
                            index   <= SLAVE_LEN'({index, gnt_sel_c});
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    CONNECT: begin
                        state <= CONNECT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.m1_grant     = m1_grant;
    assign bus.m2_grant     = m2_grant;
    assign bus.arbitor_busy = arbitor_busy;
    assign bus.bus_busy     = bus_busy;
    assign bus.master_sel   = master_sel;
    assign bus.slave_sel    = slave_sel;
    assign bus.slave_en     = slave_en;
    assign bus.sel_error    = sel_error;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected outputs, a negedge monitor compares.
module tb_bus_arbiter;
    localparam int unsigned SLAVE_LEN  = 2;
    localparam int unsigned NUM_SLAVES = 3;
    localparam logic [10:0] ZERO = 11'b0;
    localparam logic [10:0] SERR = 11'b1;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [10:0] v;
    } exp_t;

    logic clk;
    logic reset;
    int   passed;
    int   total;
    exp_t q[$];

    bus_arbiter_if #(.SLAVE_LEN(SLAVE_LEN), .NUM_SLAVES(NUM_SLAVES)) bif ();

    bus_arbiter #(
        .SLAVE_LEN  (SLAVE_LEN),
        .NUM_SLAVES (NUM_SLAVES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {m1_grant, m2_grant, arbitor_busy, bus_busy, master_sel, slave_sel[1:0], slave_en[2:0], sel_error}
    function automatic logic [10:0] outs();
        return {bif.m1_grant, bif.m2_grant, bif.arbitor_busy, bif.bus_busy, bif.master_sel,
                bif.slave_sel, bif.slave_en, bif.sel_error};
    endfunction

    function automatic logic [10:0] ex_grant(input bit m);
        return {~m, m, 1'b1, 1'b0, m, 2'b00, 3'b000, 1'b0};
    endfunction

    function automatic logic [10:0] ex_conn(input bit m, input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        return {~m, m, 1'b1, 1'b1, m, idx, oh, 1'b0};
    endfunction

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.nm, outs(), e.v);
        end
    end

    task automatic drive(input bit r1, input bit r2, input bit s1, input bit s2,
                         input bit d1, input bit d2);
        bif.m1_request      = r1;
        bif.m2_request      = r2;
        bif.m1_slave_select = s1;
        bif.m2_slave_select = s2;
        bif.m1_trans_done   = d1;
        bif.m2_trans_done   = d2;
    endtask

    // Expected value describes the outputs after the next rising edge.
    task automatic cyc(input string nm, input logic [10:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic set_sel(input bit m, input bit b);
        if (m) bif.m2_slave_select = b;
        else   bif.m1_slave_select = b;
    endtask

    task automatic connect_xact(input bit m, input logic [1:0] idx, input bit other_req, input string nm);
        if (m) drive(other_req, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        else   drive(1'b1, other_req, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({nm, "_grant"}, ex_grant(m));
        set_sel(m, idx[1]);
        cyc({nm, "_sel_msb"}, ex_grant(m));
        set_sel(m, idx[0]);
        cyc({nm, "_sel_lsb"}, ex_grant(m));
        set_sel(m, 1'b0);
        cyc({nm, "_connect"}, ex_conn(m, idx));
    endtask

    task automatic release_xact(input bit m, input string nm);
        if (m) bif.m2_trans_done = 1'b1;
        else   bif.m1_trans_done = 1'b1;
        cyc({nm, "_release"}, ZERO);
        bif.m1_trans_done = 1'b0;
        bif.m2_trans_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

    initial begin
        bit m2nd;
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset_a", ZERO);
        cyc("reset_b", ZERO);
        reset = 1'b1;
        cyc("idle", ZERO);

        // Tie: M1 first; second tie goes to M1 (fixed) or M2 (round robin).
        connect_xact(1'b0, 2'd1, 1'b1, "tie1");
        release_xact(1'b0, "tie1");
        m2nd = RR;
        connect_xact(m2nd, 2'd1, 1'b1, "tie2");
        release_xact(m2nd, "tie2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tie_idle", ZERO);

        // M1 alone, index 2, trans_done while request still held.
        connect_xact(1'b0, 2'd2, 1'b0, "m1");
        cyc("m1_hold", ex_conn(1'b0, 2'd2));
        release_xact(1'b0, "m1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("m1_idle", ZERO);

        // trans_done during SELECT is ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sdone_grant", ex_grant(1'b0));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("sdone_msb", ex_grant(1'b0));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sdone_lsb", ex_grant(1'b0));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sdone_connect", ex_conn(1'b0, 2'd1));
        release_xact(1'b0, "sdone");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sdone_idle", ZERO);

        // M2 sends index 3: out of range.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("oor_grant", ex_grant(1'b1));
        bif.m2_slave_select = 1'b1;
        cyc("oor_msb", ex_grant(1'b1));
        cyc("oor_lsb", ex_grant(1'b1));
        cyc("oor_error", SERR);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("oor_pulse_end", ZERO);

        // Abort in CONNECT and in SELECT.
        connect_xact(1'b0, 2'd0, 1'b0, "abc");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("abc_abort", ZERO);
        cyc("abc_no_serr", ZERO);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("abs_grant", ex_grant(1'b1));
        bif.m2_slave_select = 1'b1;
        cyc("abs_msb", ex_grant(1'b1));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("abs_abort", ZERO);
        cyc("abs_idle", ZERO);

        // Non-granted master activity during CONNECT changes nothing.
        connect_xact(1'b0, 2'd2, 1'b0, "ign");
        for (int k = 0; k < 4; k++) begin
            bif.m2_request      = 1'b1;
            bif.m2_trans_done   = k[0];
            bif.m2_slave_select = k[1];
            cyc("ign_hold", ex_conn(1'b0, 2'd2));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        release_xact(1'b0, "ign");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ign_idle", ZERO);

        // Reset mid-CONNECT clears outputs with no clock edge.
        connect_xact(1'b1, 2'd1, 1'b0, "rst");
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_async", outs(), ZERO);
        cyc("rst_low", ZERO);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst_regrant", ex_grant(1'b1));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst_drop", ZERO);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
